// File: rtl/msdap_input_stage_if.sv
// Signal bundle between the serial audio source, the MSDAP input stage
// and the ALU side: serial input, data-memory write port, ALU control.
//   master : source/ALU side (drives in_en, frame, in_bit, alu_busy)
//   slave  : input stage (drives wr_*, current_data_addr, alu_start,
//            sleep, overrun)
interface msdap_input_stage_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              in_en;
    logic              frame;
    logic              in_bit;
    logic              alu_busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] current_data_addr;
    logic              alu_start;
    logic              sleep;
    logic              overrun;

    modport master (
        output in_en, frame, in_bit, alu_busy,
        input  wr_en, wr_addr, wr_data, current_data_addr,
        input  alu_start, sleep, overrun
    );

    modport slave (
        input  in_en, frame, in_bit, alu_busy,
        output wr_en, wr_addr, wr_data, current_data_addr,
        output alu_start, sleep, overrun
    );
endinterface

// File: rtl/msdap_input_stage.sv
// MSDAP input stage: deserialises a framed MSB-first bit stream into
// DATA_W-bit samples, writes them to the circular data memory, starts
// the ALU per sample, and flags sleep (long zero runs) and overrun.
// Ports: clk, clear (sync, active-high), bus (msdap_input_stage_if.slave)
module msdap_input_stage #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int ZERO_LIMIT = 800
) (
    input logic                clk,
    input logic                clear,
    msdap_input_stage_if.slave bus
);
    localparam int CW = $clog2(DATA_W);
    localparam int ZW = $clog2(ZERO_LIMIT + 1);
    localparam logic [ZW-1:0] ZLIM = ZW'(ZERO_LIMIT);
    localparam logic [CW-1:0] CNT0 = CW'(DATA_W - 2);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WRITE,
        START
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shifted;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ZW-1:0]     zero_cnt;
    logic [ZW-1:0]     zc_nxt;
    logic              sleep_nxt;
    logic              sof;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [ADDR_W-1:0] cur_q;
    logic              start_q;
    logic              sleep_q;
    logic              overrun_q;

    assign sof     = bus.in_en & bus.frame;
    assign shifted = {shreg[DATA_W-2:0], bus.in_bit};

    assign bus.wr_en             = wr_en_q;
    assign bus.wr_addr           = wr_addr_q;
    assign bus.wr_data           = wr_data_q;
    assign bus.current_data_addr = cur_q;
    assign bus.alu_start         = start_q;
    assign bus.sleep             = sleep_q;
    assign bus.overrun           = overrun_q;

    // A frame strobe inside SHIFT resyncs, so it must not complete a word.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (sof) state_nxt = SHIFT;
            SHIFT: begin
                if (bus.in_en && !bus.frame && bit_cnt == '0)
                    state_nxt = WRITE;
            end
            WRITE:   state_nxt = START;
            START:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // In WRITE, shreg holds the complete word; the counter saturates.
    always_comb begin
        zc_nxt    = zero_cnt;
        sleep_nxt = sleep_q;
        if (shreg == '0) begin
            if (zero_cnt != ZLIM) zc_nxt = zero_cnt + 1'b1;
            if (zc_nxt == ZLIM) sleep_nxt = 1'b1;
        end else begin
            zc_nxt    = '0;
            sleep_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            wr_ptr    <= '0;
            zero_cnt  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cur_q     <= '0;
            start_q   <= 1'b0;
            sleep_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            wr_en_q <= 1'b0;
            start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (sof) begin
                        shreg   <= DATA_W'(bus.in_bit);
                        bit_cnt <= CNT0;
                    end
                end
                SHIFT: begin
                    if (sof) begin
                        shreg   <= DATA_W'(bus.in_bit);
                        bit_cnt <= CNT0;
                    end else if (bus.in_en) begin
                        shreg <= shifted;
                        if (bit_cnt == '0) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= wr_ptr;
                            wr_data_q <= shifted;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
                // Start decision uses the post-update sleep so the
                // sample that enters sleep does not start the ALU.
                WRITE: begin
                    cur_q    <= wr_ptr;
                    wr_ptr   <= wr_ptr + 1'b1;
                    zero_cnt <= zc_nxt;
                    sleep_q  <= sleep_nxt;
                    if (!sleep_nxt) begin
                        if (!bus.alu_busy) start_q   <= 1'b1;
                        else               overrun_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_msdap_input_stage.sv
// Scoreboard bench for msdap_input_stage: expected writes are queued
// as words are driven and compared when the DUT writes/starts.
module tb_msdap_input_stage;
    logic clk = 1'b0;
    logic clear = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    msdap_input_stage_if #(.DATA_W(16), .ADDR_W(8)) bus ();

    msdap_input_stage #(
        .DATA_W(16), .ADDR_W(8), .ZERO_LIMIT(800)
    ) dut (
        .clk  (clk),
        .clear(clear),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        logic        start;
        logic        slp;
        logic        ov;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   chk_start = 0;

    logic [7:0] m_wptr = '0;
    int         m_zc = 0;
    logic       m_slp = 1'b0;
    logic       m_ov = 1'b0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    // Expected behaviour of one stored word.
    task automatic push_exp(input logic [15:0] w);
        exp_t e;
        e.addr = m_wptr;
        e.data = w;
        m_wptr = m_wptr + 8'd1;
        if (w == 16'h0) begin
            if (m_zc < 800) m_zc++;
            if (m_zc == 800) m_slp = 1'b1;
        end else begin
            m_zc  = 0;
            m_slp = 1'b0;
        end
        e.start = !m_slp && !bus.alu_busy;
        if (!m_slp && bus.alu_busy) m_ov = 1'b1;
        e.slp = m_slp;
        e.ov  = m_ov;
        q.push_back(e);
    endtask

    // One bit every 4 clk; frame with the first bit.
    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.in_en  = 1'b1;
            bus.frame  = (i == 0);
            bus.in_bit = w[15-i];
            @(posedge clk); #1;
            bus.in_en = 1'b0;
            bus.frame = 1'b0;
            @(posedge clk);
            @(posedge clk);
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        push_exp(w);
        send_bits(w, 16);
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        m_wptr = '0;
        m_zc   = 0;
        m_slp  = 1'b0;
        m_ov   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_start) begin
            chk_start = 0;
            check("alu_start", 32'(bus.alu_start), 32'(cur.start));
            check("sleep", 32'(bus.sleep), 32'(cur.slp));
            check("overrun", 32'(bus.overrun), 32'(cur.ov));
            check("cur_addr", 32'(bus.current_data_addr),
                  32'(cur.addr));
        end else if (bus.alu_start) begin
            check("stray_start", 32'(bus.alu_start), 32'd0);
        end
        if (bus.wr_en) begin
            if (q.size() == 0) begin
                check("extra_wr", 32'(bus.wr_en), 32'd0);
            end else begin
                cur = q.pop_front();
                check("wr_addr", 32'(bus.wr_addr), 32'(cur.addr));
                check("wr_data", 32'(bus.wr_data), 32'(cur.data));
                chk_start = 1;
            end
        end
    end

    task automatic check_zero(input string tag);
        @(negedge clk);
        check({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
        check({tag, "_start"}, 32'(bus.alu_start), 32'd0);
        check({tag, "_sleep"}, 32'(bus.sleep), 32'd0);
        check({tag, "_ovr"}, 32'(bus.overrun), 32'd0);
        check({tag, "_cur"}, 32'(bus.current_data_addr), 32'd0);
        check({tag, "_waddr"}, 32'(bus.wr_addr), 32'd0);
        check({tag, "_wdata"}, 32'(bus.wr_data), 32'd0);
    endtask

    initial begin
        bus.in_en    = 1'b0;
        bus.frame    = 1'b0;
        bus.in_bit   = 1'b0;
        bus.alu_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 clear = 1'b0;
        check_zero("reset");

        // basic word
        send_word(16'h1234);

        // pointer wrap from a fresh clear
        do_clear();
        for (int i = 1; i <= 258; i++) send_word(16'(i));

        // sleep entry and exit
        for (int i = 0; i < 800; i++) send_word(16'h0000);
        send_word(16'h0005);

        // overrun
        bus.alu_busy = 1'b1;
        send_word(16'h0777);
        bus.alu_busy = 1'b0;
        send_word(16'h0888);

        // resync after 7 bits
        send_bits(16'hA5A5, 7);
        send_word(16'hBEEF);

        // clear in the middle of a word
        send_bits(16'hFFFF, 5);
        do_clear();
        check_zero("clear");
        send_word(16'h00AA);

        repeat (8) @(posedge clk);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
